// File: rtl/id_scan_pkg.sv
// Shared encodings for the identifier stream scanner: FSM states,
// character classes and the ASCII bounds used by the classifier.
package id_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ALPHA,
        DIGIT
    } state_t;

    typedef enum logic [1:0] {
        CLS_DIGIT,
        CLS_ALPHA,
        CLS_OTHER
    } cls_t;

    localparam logic [7:0] ASC_0      = 8'd48;
    localparam logic [7:0] ASC_9      = 8'd57;
    localparam logic [7:0] ASC_UC_A   = 8'd65;
    localparam logic [7:0] ASC_UC_Z   = 8'd90;
    localparam logic [7:0] ASC_LC_A   = 8'd97;
    localparam logic [7:0] ASC_LC_Z   = 8'd122;
    localparam logic [7:0] ASC_USCORE = 8'd95;

endpackage

// File: rtl/id_char_class.sv
// Combinational byte-to-class mapping. Anything that is neither a digit
// nor a letter (optionally including underscore) is a separator.
module id_char_class
    import id_scan_pkg::*;
#(
    parameter bit ALLOW_UNDERSCORE = 1'b0
) (
    input  logic [7:0] char,
    output cls_t       cls
);

    // Classify the incoming byte
    always_comb begin
        cls = CLS_OTHER;
        if (char >= ASC_0 && char <= ASC_9) begin
            cls = CLS_DIGIT;
        end else if ((char >= ASC_UC_A && char <= ASC_UC_Z) ||
                     (char >= ASC_LC_A && char <= ASC_LC_Z) ||
                     (ALLOW_UNDERSCORE && char == ASC_USCORE)) begin
            cls = CLS_ALPHA;
        end
    end

endmodule

// File: rtl/id_stream_scanner.sv
// Byte-serial identifier scanner: tracks letter/digit runs, flags runs that
// end in enough letters followed by enough digits, and reports each token
// closed by a separator together with its length and a running accept count.
module id_stream_scanner
    import id_scan_pkg::*;
#(
    parameter int unsigned MIN_ALPHA        = 1,
    parameter int unsigned MIN_DIGIT        = 1,
    parameter bit          ALLOW_UNDERSCORE = 1'b0,
    parameter int unsigned LEN_W            = 5,
    parameter int unsigned CNT_W            = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char,
    output logic             match,
    output logic             tok_done,
    output logic             tok_ok,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] tok_count
);

    // Run counters only need to reach their minimums, so they saturate there
    localparam int unsigned AW = $clog2(MIN_ALPHA + 1);
    localparam int unsigned DW = $clog2(MIN_DIGIT + 1);
    localparam logic [AW-1:0]    A_MAX   = AW'(MIN_ALPHA);
    localparam logic [DW-1:0]    D_MAX   = DW'(MIN_DIGIT);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    cls_t             cls;
    state_t           state, state_next;
    logic [AW-1:0]    a_run, a_next;
    logic [DW-1:0]    d_run, d_next;
    logic [LEN_W-1:0] len;
    logic             match_next;

    id_char_class #(
        .ALLOW_UNDERSCORE(ALLOW_UNDERSCORE)
    ) u_class (
        .char(char),
        .cls (cls)
    );

    // Next state and run counters for the sampled character
    always_comb begin
        state_next = state;
        a_next     = a_run;
        d_next     = d_run;
        case (cls)
            CLS_ALPHA: begin
                state_next = ALPHA;
                if (state == ALPHA) begin
                    if (a_run < A_MAX) a_next = a_run + 1'b1;
                end else begin
                    a_next = AW'(1);
                end
            end
            CLS_DIGIT: begin
                // Digits before any letter leave the run in IDLE
                if (state != IDLE) begin
                    state_next = DIGIT;
                    if (state == ALPHA) begin
                        d_next = DW'(1);
                    end else if (d_run < D_MAX) begin
                        d_next = d_run + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                a_next     = '0;
                d_next     = '0;
            end
        endcase
        match_next = (state_next == DIGIT) && (a_run >= A_MAX) && (d_next >= D_MAX);
    end

    // FSM, counters, token bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_run     <= '0;
            d_run     <= '0;
            len       <= '0;
            match     <= 1'b0;
            tok_done  <= 1'b0;
            tok_ok    <= 1'b0;
            tok_len   <= '0;
            tok_count <= '0;
        end else begin
            tok_done <= 1'b0;
            if (char_valid) begin
                state <= state_next;
                a_run <= a_next;
                d_run <= d_next;
                match <= match_next;
                if (cls == CLS_OTHER) begin
                    if (len != '0) begin
                        tok_done <= 1'b1;
                        tok_ok   <= match;
                        tok_len  <= len;
                        if (match) tok_count <= tok_count + 1'b1;
                    end
                    len <= '0;
                end else if (len != LEN_MAX) begin
                    len <= len + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_stream_scanner.sv
// Directed bench for id_stream_scanner: four instances with different
// parameter sets share one input stream; each section checks the instance
// whose configuration it targets against hand-computed values.
module tb_id_stream_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char = 8'd0;

    always #5 clk = ~clk;

    // defaults
    logic       m_d, td_d, ok_d;
    logic [4:0] len_d;
    logic [7:0] cnt_d;
    // MIN_ALPHA=2, MIN_DIGIT=2
    logic       m_2, td_2, ok_2;
    logic [4:0] len_2;
    logic [7:0] cnt_2;
    // LEN_W=5, CNT_W=2
    logic       m_s, td_s, ok_s;
    logic [4:0] len_s;
    logic [1:0] cnt_s;
    // ALLOW_UNDERSCORE=1
    logic       m_u, td_u, ok_u;
    logic [4:0] len_u;
    logic [7:0] cnt_u;

    id_stream_scanner dut_def (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .match(m_d), .tok_done(td_d), .tok_ok(ok_d), .tok_len(len_d), .tok_count(cnt_d)
    );

    id_stream_scanner #(.MIN_ALPHA(2), .MIN_DIGIT(2)) dut_22 (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .match(m_2), .tok_done(td_2), .tok_ok(ok_2), .tok_len(len_2), .tok_count(cnt_2)
    );

    id_stream_scanner #(.LEN_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .match(m_s), .tok_done(td_s), .tok_ok(ok_s), .tok_len(len_s), .tok_count(cnt_s)
    );

    id_stream_scanner #(.ALLOW_UNDERSCORE(1'b1)) dut_us (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(char),
        .match(m_u), .tok_done(td_u), .tok_ok(ok_u), .tok_len(len_u), .tok_count(cnt_u)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One character on one edge; outputs are sampled 1 time unit after it
    task automatic send(input logic [7:0] c);
        char_valid = 1'b1;
        char       = c;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic gap(input int unsigned n);
        char_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        char_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        check("rst_match", m_d, 0);
        check("rst_done", td_d, 0);
        check("rst_ok", ok_d, 0);
        check("rst_len", len_d, 0);
        check("rst_cnt", cnt_d, 0);

        // "a1 " with defaults
        send("a");  check("a1_m_a", m_d, 0);
        send("1");  check("a1_m_1", m_d, 1); check("a1_nodone", td_d, 0);
        send(" ");
        check("a1_done", td_d, 1); check("a1_ok", ok_d, 1);
        check("a1_len", len_d, 2); check("a1_cnt", cnt_d, 1); check("a1_m_sp", m_d, 0);
        gap(1);
        check("a1_pulse1", td_d, 0); check("a1_lenhold", len_d, 2);

        // "1a2b3;"
        send("1"); check("mix_m0", m_d, 0);
        send("a"); check("mix_m1", m_d, 0);
        send("2"); check("mix_m2", m_d, 1);
        send("b"); check("mix_m3", m_d, 0);
        send("3"); check("mix_m4", m_d, 1);
        send(";");
        check("mix_done", td_d, 1); check("mix_ok", ok_d, 1);
        check("mix_len", len_d, 5); check("mix_cnt", cnt_d, 2);

        // MIN_ALPHA=2, MIN_DIGIT=2
        do_reset();
        send("a"); send("1"); send("2"); send(" ");
        check("22_a12_done", td_2, 1); check("22_a12_ok", ok_2, 0);
        check("22_a12_len", len_2, 3); check("22_a12_cnt", cnt_2, 0);
        send("a"); send("b"); send("1"); send(" ");
        check("22_ab1_done", td_2, 1); check("22_ab1_ok", ok_2, 0);
        send("a"); send("b"); send("1");
        check("22_ab1_m", m_2, 0);
        send("2");
        check("22_ab12_m", m_2, 1);
        send(" ");
        check("22_ab12_ok", ok_2, 1); check("22_ab12_len", len_2, 4);
        check("22_ab12_cnt", cnt_2, 1);

        // idle cycles inside a run
        do_reset();
        send("a"); check("gap_m_a", m_d, 0);
        char_valid = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("gap_m_hold", m_d, 0);
            check("gap_nodone", td_d, 0);
        end
        send("1"); check("gap_m_1", m_d, 1);
        send(" ");
        check("gap_done", td_d, 1); check("gap_len", len_d, 2); check("gap_ok", ok_d, 1);
        send(" ");
        check("gap_sp2_nodone", td_d, 0); check("gap_cnt", cnt_d, 1);

        // length saturation and count wrap (LEN_W=5, CNT_W=2)
        do_reset();
        for (int unsigned i = 0; i < 40; i++) send("x");
        send("7");
        send(" ");
        check("sat_done", td_s, 1); check("sat_len", len_s, 31);
        check("sat_ok", ok_s, 1); check("sat_cnt1", cnt_s, 1);
        for (int unsigned k = 2; k <= 5; k++) begin
            send("a"); send("1"); send(" ");
            check("sat_cnt_wrap", cnt_s, k % 4);
        end

        // reset mid-run discards the run
        do_reset();
        send("a"); send("b");
        do_reset();
        check("mid_rst_nodone", td_d, 0); check("mid_rst_m", m_d, 0);
        send("1"); check("mid_rst_m1", m_d, 0);
        send(" ");
        check("mid_rst_done", td_d, 1); check("mid_rst_ok", ok_d, 0);
        check("mid_rst_len", len_d, 1); check("mid_rst_cnt", cnt_d, 0);

        // reset dominates a valid separator on the same edge
        do_reset();
        send("a"); send("1");
        reset      = 1'b1;
        char_valid = 1'b1;
        char       = " ";
        @(posedge clk);
        #1;
        reset      = 1'b0;
        char_valid = 1'b0;
        check("rst_dom_done", td_d, 0); check("rst_dom_cnt", cnt_d, 0);
        check("rst_dom_m", m_d, 0);

        // underscore as letter vs separator
        do_reset();
        send("_");
        check("us_def_nodone", td_d, 0);
        send("9");
        check("us_m", m_u, 1); check("us_def_m", m_d, 0);
        send(" ");
        check("us_done", td_u, 1); check("us_ok", ok_u, 1);
        check("us_len", len_u, 2); check("us_cnt", cnt_u, 1);
        check("us_def_done", td_d, 1); check("us_def_ok", ok_d, 0);
        check("us_def_len", len_d, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
